// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch, data load/store) in
// front of one shared single-port memory. Only one access is outstanding at a
// time. Data normally wins, but a fetch that keeps waiting is granted after
// MAX_STREAK consecutive data grants.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_done) and address
//   if_done/if_rdata    one-cycle fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_done), 1 = store
//   d_done/d_rdata      one-cycle data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, stable while mem_req=1
//   mem_ready/mem_rdata memory completion strobe and read data
//   busy                high whenever the FSM is not idle
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_D  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q,   if_done_d;
  logic                d_done_q,    d_done_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic                busy_q,      busy_d;

  // A done cycle carries the finishing requester's stale request; no grant is
  // made in it, so that requester is masked and arbitration resumes next cycle.
  // This also lets a continuously held data requester build up its streak.
  logic arb_en;
  assign arb_en = !(if_done_q || d_done_q);

  // Next-state, arbitration and transaction bookkeeping
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_d    = streak_q;

    case (state_q)
      IDLE: begin
        if (arb_en) begin
          if (d_req && !(if_req && (streak_q == STREAK_MAX))) begin
            state_d     = SERVE_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Streak only counts data grants that made a fetch wait
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else if (if_req) begin
            state_d     = SERVE_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end

      SERVE_IF: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end

      SERVE_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_done_d  = 1'b1;
          // Stores complete without touching the load data register
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      streak_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      streak_q    <= streak_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table for single transactions plus
// hand-written sequences for contention, streak limiting and mid-access reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ifd;
    logic        e_dd;
    logic        e_busy;
    logic [31:0] e_ifr;
    logic [31:0] e_dr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dwe,
                              logic [31:0] da, logic [31:0] dw, logic rdy,
                              logic [31:0] rd, logic er, logic ewe,
                              logic [31:0] ea, logic [31:0] ew, logic eifd,
                              logic edd, logic eb, logic [31:0] eifr,
                              logic [31:0] edr);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;   v.d_we = dwe;
    v.d_addr = da;  v.d_wdata = dw;  v.rdy = rdy;    v.rdata = rd;
    v.e_req = er;   v.e_we = ewe;    v.e_addr = ea;  v.e_wdata = ew;
    v.e_ifd = eifd; v.e_dd = edd;    v.e_busy = eb;  v.e_ifr = eifr;
    v.e_dr = edr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  int  n_order;
  byte order[2];
  logic both_done;
  logic first_addr_seen;
  logic [31:0] first_addr;
  byte grants[8];
  byte exp_grants[8];
  int  n_grants;
  logic prev_req;
  logic saw_d_done;
  logic got_if;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset if_done", 32'(if_done), 32'd0);
    check("reset d_done", 32'(d_done), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset d_rdata", d_rdata, 32'd0);
    do_reset();

    // Fetch with ready tied high, stale if_req in done cycle, idle
    vecs[0]  = mk(1, 32'h10, 0, 0, 0, 0, 1, 32'h13,
                  1, 0, 32'h10, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 32'h10, 0, 0, 0, 0, 1, 32'h13,
                  0, 0, 32'h10, 0, 1, 0, 0, 32'h13, 0);
    vecs[2]  = mk(1, 32'h10, 0, 0, 0, 0, 1, 32'h13,
                  0, 0, 32'h10, 0, 0, 0, 0, 32'h13, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'h10, 0, 0, 0, 0, 32'h13, 0);
    // Store with mem_ready four cycles late: mem_req high five cycles
    for (int i = 4; i <= 8; i++)
      vecs[i] = mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0,
                   1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 1, 32'h13, 0);
    vecs[9]  = mk(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 1, 32'hFFFFFFFF,
                  0, 0, 32'h100, 32'hDEADBEEF, 0, 1, 0, 32'h13, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h13, 0);
    // Load whose d_req drops one cycle after grant
    vecs[11] = mk(0, 0, 1, 0, 32'h200, 32'h55, 0, 0,
                  1, 0, 32'h200, 32'h55, 0, 0, 1, 32'h13, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                  1, 0, 32'h200, 32'h55, 0, 0, 1, 32'h13, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001,
                  0, 0, 32'h200, 32'h55, 0, 1, 0, 32'h13, 32'hCAFE0001);
    // mem_ready high while idle must be ignored
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 32'h77,
                  0, 0, 32'h200, 32'h55, 0, 0, 0, 32'h13, 32'hCAFE0001);
    // Unaligned fetch address passes through unchanged
    vecs[15] = mk(1, 32'h3, 0, 0, 0, 0, 1, 32'h11,
                  1, 0, 32'h3, 0, 0, 0, 1, 32'h13, 32'hCAFE0001);
    vecs[16] = mk(1, 32'h3, 0, 0, 0, 0, 1, 32'h11,
                  0, 0, 32'h3, 0, 1, 0, 0, 32'h11, 32'hCAFE0001);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'h3, 0, 0, 0, 0, 32'h11, 32'hCAFE0001);

    for (int i = 0; i < 18; i++) begin
      if_req = vecs[i].if_req;  if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req;    d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr;  d_wdata = vecs[i].d_wdata;
      mem_ready = vecs[i].rdy;  mem_rdata = vecs[i].rdata;
      step();
      check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d if_done", i), 32'(if_done), 32'(vecs[i].e_ifd));
      check($sformatf("v%0d d_done", i), 32'(d_done), 32'(vecs[i].e_dd));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_ifr);
      check($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_dr);
    end

    // Simultaneous fetch and load: data first, dones in order, never together
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    n_order = 0; both_done = 1'b0; first_addr_seen = 1'b0; first_addr = '0;
    for (int c = 0; c < 20 && n_order < 2; c++) begin
      step();
      if (mem_req && !first_addr_seen) begin
        first_addr_seen = 1'b1;
        first_addr = mem_addr;
      end
      if (if_done && d_done) both_done = 1'b1;
      if (d_done && n_order < 2) begin order[n_order] = 8'd68; n_order++; d_req = 1'b0; end
      if (if_done && n_order < 2) begin order[n_order] = 8'd73; n_order++; if_req = 1'b0; end
    end
    check("contend first addr", first_addr, 32'h200);
    check("contend done count", 32'(n_order), 32'd2);
    check("contend first done", 32'(order[0]), 32'd68);
    check("contend second done", 32'(order[1]), 32'd73);
    check("contend overlap", 32'(both_done), 32'd0);
    check("contend d_rdata", d_rdata, 32'h1234);
    idle_inputs();
    step();

    // Both held continuously: streak limit forces D,D,D,I,D,D,D,I
    do_reset();
    exp_grants = '{8'd68, 8'd68, 8'd68, 8'd73, 8'd68, 8'd68, 8'd68, 8'd73};
    grants = '{default: 8'd0};
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    mem_ready = 1'b1; mem_rdata = '0;
    n_grants = 0; prev_req = 1'b0;
    for (int c = 0; c < 60 && n_grants < 8; c++) begin
      step();
      if (mem_req && !prev_req) begin
        grants[n_grants] = (mem_addr == 32'h2000) ? 8'd68 : 8'd73;
        n_grants++;
      end
      prev_req = mem_req;
    end
    check("streak grant count", 32'(n_grants), 32'd8);
    for (int g = 0; g < 8; g++)
      check($sformatf("streak grant %0d", g), 32'(grants[g]), 32'(exp_grants[g]));
    idle_inputs();
    step();
    step();

    // Reset in the middle of a stalled store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5A5A5A5;
    mem_ready = 1'b0;
    step();
    step();
    check("pre-reset mem_req", 32'(mem_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset mem_req", 32'(mem_req), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset mem_we", 32'(mem_we), 32'd0);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    saw_d_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (d_done) saw_d_done = 1'b1;
    end
    check("no d_done after reset", 32'(saw_d_done), 32'd0);
    if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h00C0FFEE;
    got_if = 1'b0;
    for (int c = 0; c < 10 && !got_if; c++) begin
      step();
      if (if_done) begin
        got_if = 1'b1;
        if_req = 1'b0;
      end
    end
    check("post-reset fetch done", 32'(got_if), 32'd1);
    check("post-reset if_rdata", if_rdata, 32'h00C0FFEE);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
